// File: rtl/range_scan_ctrl.sv
// ============================================================================
// range_scan_ctrl
// ----------------------------------------------------------------------------
// Sequencer for the Collatz `range` engine. It launches a run from a requested
// start value and waits for `done`. It then sweeps the engine's result RAM once
// to find the largest iteration count and its index. Afterwards it serves
// random-access reads of that RAM for display browsing.
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   req           in   one-cycle run request (accepted in IDLE / DISPLAY only)
//   req_start     in   start value, latched when req is accepted
//   sel           in   browse index, used in DISPLAY
//   go            out  one-cycle launch pulse to range
//   start         out  start value to range, held until the next accepted req
//   done          in   completion level from range
//   n             out  RAM read address to range
//   count         in   RAM read data, valid the cycle after n is presented
//   busy          out  high in LAUNCH, SETTLE, RUN and SCAN
//   result_valid  out  sweep results are valid
//   error         out  the last run hit the watchdog limit
//   max_count     out  largest count found by the sweep
//   max_index     out  index of max_count (lowest index on ties)
//   sel_count     out  count at sel, refreshed only in DISPLAY
// ============================================================================
module range_scan_ctrl #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int TIMEOUT       = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req,
    input  logic [31:0]              req_start,
    input  logic [RAM_ADDR_BITS-1:0] sel,
    output logic                     go,
    output logic [31:0]              start,
    input  logic                     done,
    output logic [RAM_ADDR_BITS-1:0] n,
    input  logic [15:0]              count,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     error,
    output logic [15:0]              max_count,
    output logic [RAM_ADDR_BITS-1:0] max_index,
    output logic [15:0]              sel_count
);

    // The sweep counter is one bit wider than the address so that the
    // terminal value RAM_WORDS is representable and never wraps to 0.
    localparam int CW = RAM_ADDR_BITS + 1;

    localparam logic [CW-1:0] SCAN_FIRST = CW'(1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(RAM_WORDS);
    localparam logic [CW-1:0] ADDR_LAST  = CW'(RAM_WORDS - 1);
    localparam logic [31:0]   WDOG_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_RUN,
        S_SCAN,
        S_DISPLAY
    } state_t;

    state_t                   state_q,        state_d;
    logic [31:0]              start_q,        start_d;
    logic [RAM_ADDR_BITS-1:0] n_q,            n_d;
    logic [RAM_ADDR_BITS-1:0] n_prev_q,       n_prev_d;
    logic [CW-1:0]            scan_cnt_q,     scan_cnt_d;
    logic [31:0]              wdog_q,         wdog_d;
    logic                     result_valid_q, result_valid_d;
    logic                     error_q,        error_d;
    logic [15:0]              max_count_q,    max_count_d;
    logic [RAM_ADDR_BITS-1:0] max_index_q,    max_index_d;
    logic [15:0]              sel_count_q,    sel_count_d;

    logic                     accept;
    logic [CW-1:0]            scan_cnt_inc;

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        n_d            = n_q;
        // Address presented one cycle earlier; count in this cycle belongs to it.
        n_prev_d       = n_q;
        scan_cnt_d     = scan_cnt_q;
        wdog_d         = wdog_q;
        result_valid_d = result_valid_q;
        error_d        = error_q;
        max_count_d    = max_count_q;
        max_index_d    = max_index_q;
        sel_count_d    = sel_count_q;
        scan_cnt_inc   = scan_cnt_q + SCAN_FIRST;

        // Requests are only sampled in IDLE and DISPLAY; anything arriving
        // while busy is dropped, not queued.
        accept = req && ((state_q == S_IDLE) || (state_q == S_DISPLAY));

        case (state_q)
            S_IDLE: begin
                // Acceptance is handled below, shared with DISPLAY.
            end

            S_LAUNCH: begin
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                // range may still be showing done from the previous run, so
                // this cycle is spent ignoring it.
                wdog_d  = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                // done takes priority over the watchdog in the same cycle.
                if (done) begin
                    n_d        = '0;
                    scan_cnt_d = '0;
                    state_d    = S_SCAN;
                end else if (wdog_q == WDOG_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end

            S_SCAN: begin
                // scan_cnt_q == 0 is the cycle the first address is on the bus;
                // its data shows up when scan_cnt_q == 1.
                if (scan_cnt_q != '0) begin
                    if ((scan_cnt_q == SCAN_FIRST) || (count > max_count_q)) begin
                        max_count_d = count;
                        max_index_d = n_prev_q;
                    end
                end
                if (scan_cnt_q == SCAN_LAST) begin
                    result_valid_d = 1'b1;
                    state_d        = S_DISPLAY;
                end else begin
                    scan_cnt_d = scan_cnt_inc;
                    // After the last address the bus holds for one more cycle
                    // so the final word can be compared.
                    if (scan_cnt_q < ADDR_LAST) begin
                        n_d = scan_cnt_inc[RAM_ADDR_BITS-1:0];
                    end
                end
            end

            S_DISPLAY: begin
                n_d         = sel;
                sel_count_d = count;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            start_d        = req_start;
            result_valid_d = 1'b0;
            error_d        = 1'b0;
            max_count_d    = '0;
            max_index_d    = '0;
            state_d        = S_LAUNCH;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            start_q        <= '0;
            n_q            <= '0;
            n_prev_q       <= '0;
            scan_cnt_q     <= '0;
            wdog_q         <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            max_count_q    <= '0;
            max_index_q    <= '0;
            sel_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            n_q            <= n_d;
            n_prev_q       <= n_prev_d;
            scan_cnt_q     <= scan_cnt_d;
            wdog_q         <= wdog_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            max_count_q    <= max_count_d;
            max_index_q    <= max_index_d;
            sel_count_q    <= sel_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // go and busy decode directly from the state register, so both are glitch
    // free and return to 0 the moment reset_n falls.
    assign go           = (state_q == S_LAUNCH);
    assign busy         = (state_q == S_LAUNCH) || (state_q == S_SETTLE) ||
                          (state_q == S_RUN)    || (state_q == S_SCAN);
    assign start        = start_q;
    assign n            = n_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign max_count    = max_count_q;
    assign max_index    = max_index_q;
    assign sel_count    = sel_count_q;

endmodule

// File: tb/tb_range_scan_ctrl.sv
// ============================================================================
// tb_range_scan_ctrl
// ----------------------------------------------------------------------------
// Directed bench for range_scan_ctrl. A behavioural model of `range` provides
// a registered-read result RAM and a done level that stays stale through
// SETTLE and rises DONE_DELAY cycles after go. A second instance with a short
// watchdog limit and done tied low covers the timeout path.
// ============================================================================
module tb_range_scan_ctrl;

    localparam int DONE_DELAY = 100;

    logic        clk = 1'b0;
    logic        reset_n;

    // main instance
    logic        req;
    logic [31:0] req_start;
    logic [7:0]  sel;
    logic        go;
    logic [31:0] start;
    logic        done_m = 1'b1;   // stale done from a notional earlier run
    logic [7:0]  n;
    logic [15:0] count_m;
    logic        busy;
    logic        result_valid;
    logic        error;
    logic [15:0] max_count;
    logic [7:0]  max_index;
    logic [15:0] sel_count;

    // timeout instance
    logic        to_req;
    logic [31:0] to_req_start;
    logic [7:0]  to_sel;
    logic        to_go;
    logic [31:0] to_start;
    logic        to_done;
    logic [7:0]  to_n;
    logic [15:0] to_count;
    logic        to_busy;
    logic        to_result_valid;
    logic        to_error;
    logic [15:0] to_max_count;
    logic [7:0]  to_max_index;
    logic [15:0] to_sel_count;

    logic [15:0] ram [256];
    int          run_cnt = 0;
    int          go_cnt  = 0;
    int          total   = 0;
    int          bad     = 0;
    int          go_base;

    always #5 clk = ~clk;

    range_scan_ctrl #(.RAM_WORDS(256), .RAM_ADDR_BITS(8), .TIMEOUT(1000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_start    (req_start),
        .sel          (sel),
        .go           (go),
        .start        (start),
        .done         (done_m),
        .n            (n),
        .count        (count_m),
        .busy         (busy),
        .result_valid (result_valid),
        .error        (error),
        .max_count    (max_count),
        .max_index    (max_index),
        .sel_count    (sel_count)
    );

    range_scan_ctrl #(.RAM_WORDS(256), .RAM_ADDR_BITS(8), .TIMEOUT(50)) dut_to (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (to_req),
        .req_start    (to_req_start),
        .sel          (to_sel),
        .go           (to_go),
        .start        (to_start),
        .done         (to_done),
        .n            (to_n),
        .count        (to_count),
        .busy         (to_busy),
        .result_valid (to_result_valid),
        .error        (to_error),
        .max_count    (to_max_count),
        .max_index    (to_max_index),
        .sel_count    (to_sel_count)
    );

    // Behavioural range: registered RAM read; done keeps its old level for the
    // cycle after go (SETTLE), drops, then rises in cycle go+DONE_DELAY.
    always @(posedge clk) begin
        count_m <= ram[n];
        if (go) begin
            run_cnt <= 1;
        end else if (run_cnt != 0) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt == 1)
                done_m <= 1'b0;
            else if (run_cnt + 1 == DONE_DELAY)
                done_m <= 1'b1;
        end
        if (go) go_cnt <= go_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Pulse req for one edge; returns at the negedge of the LAUNCH cycle.
    task automatic launch(input logic [31:0] v);
        req       = 1'b1;
        req_start = v;
        tick(1);
        req       = 1'b0;
    endtask

    // Full run from launch: returns at the negedge of cycle go+358, the first
    // cycle in DISPLAY.
    task automatic run_and_check(input string name, input logic [15:0] exp_max,
                                 input logic [7:0] exp_idx, input logic [31:0] exp_start,
                                 input bit inject_busy_req);
        go_base = go_cnt;
        launch(exp_start);
        check({name, ".go"}, 32'(go), 32'd1);
        check({name, ".start"}, start, exp_start);
        check({name, ".rv_clr"}, 32'(result_valid), 32'd0);
        check({name, ".max_clr"}, 32'(max_count), 32'd0);
        tick(1);
        check({name, ".go_once"}, 32'(go), 32'd0);
        tick(9);
        if (inject_busy_req) begin
            req = 1'b1; req_start = 32'd99;
        end
        tick(1);
        req = 1'b0;
        check({name, ".start_hold"}, start, exp_start);
        tick(90);                                   // go+101
        check({name, ".n_first"}, 32'(n), 32'd0);
        tick(1);
        check({name, ".n_second"}, 32'(n), 32'd1);
        tick(255);                                  // go+357
        check({name, ".rv_early"}, 32'(result_valid), 32'd0);
        check({name, ".busy_scan"}, 32'(busy), 32'd1);
        tick(1);                                    // go+358
        check({name, ".rv"}, 32'(result_valid), 32'd1);
        check({name, ".busy_disp"}, 32'(busy), 32'd0);
        check({name, ".max_count"}, 32'(max_count), 32'(exp_max));
        check({name, ".max_index"}, 32'(max_index), 32'(exp_idx));
        check({name, ".error"}, 32'(error), 32'd0);
        check({name, ".go_pulses"}, 32'(go_cnt - go_base), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        req = 1'b0; req_start = '0; sel = '0;
        to_req = 1'b0; to_req_start = '0; to_sel = '0; to_done = 1'b0; to_count = 16'h1234;
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        ram[200] = 16'h0400;

        // reset values
        tick(3);
        check("rst.go", 32'(go), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.start", start, 32'd0);
        check("rst.rv", 32'(result_valid), 32'd0);
        check("rst.sel_count", 32'(sel_count), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // normal run with a busy request injected during RUN
        run_and_check("norm", 16'h0400, 8'd200, 32'd27, 1'b1);
        tick(1);
        check("norm.no_queue", 32'(busy), 32'd0);

        // browse: sel 0 -> 5 -> 255
        sel = 8'd0;   tick(3);
        check("brw.sel0", 32'(sel_count), 32'(ram[0]));
        sel = 8'd5;   tick(2);
        check("brw.sel5_lat", 32'(sel_count), 32'(ram[0]));
        tick(1);
        check("brw.sel5", 32'(sel_count), 32'(ram[5]));
        sel = 8'd255; tick(3);
        check("brw.sel255", 32'(sel_count), 32'(ram[255]));

        // tie: lowest index wins; launched from DISPLAY
        for (int i = 0; i < 256; i++) ram[i] = 16'(i % 64);
        ram[17] = 16'h0077;
        ram[90] = 16'h0077;
        run_and_check("tie", 16'h0077, 8'd17, 32'd31, 1'b0);
        tick(3);
        check("tie.sel255", 32'(sel_count), 32'(ram[255]));

        // reset mid-SCAN
        launch(32'd5);
        tick(200);
        check("mid.busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.n", 32'(n), 32'd0);
        check("mid.start", start, 32'd0);
        check("mid.go", 32'(go), 32'd0);
        check("mid.sel_count", 32'(sel_count), 32'd0);
        check("mid.max_count", 32'(max_count), 32'd0);
        check("mid.rv", 32'(result_valid), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        go_base = go_cnt;
        launch(32'd27);
        check("rel.start", start, 32'd27);
        check("rel.go", 32'(go), 32'd1);
        tick(1);
        check("rel.go_off", 32'(go), 32'd0);
        tick(5);
        check("rel.go_pulses", 32'(go_cnt - go_base), 32'd1);

        // timeout instance, TIMEOUT=50
        to_req = 1'b1; to_req_start = 32'd3;
        tick(1);                                    // go cycle
        to_req = 1'b0;
        check("to.go", 32'(to_go), 32'd1);
        tick(51);                                   // go+51, last RUN cycle
        check("to.err_early", 32'(to_error), 32'd0);
        check("to.busy_run", 32'(to_busy), 32'd1);
        to_req = 1'b1; to_req_start = 32'd7;        // coincides with timeout
        tick(1);                                    // go+52
        to_req = 1'b0;
        check("to.error", 32'(to_error), 32'd1);
        check("to.busy", 32'(to_busy), 32'd0);
        check("to.rv", 32'(to_result_valid), 32'd0);
        check("to.max_count", 32'(to_max_count), 32'd0);
        check("to.max_index", 32'(to_max_index), 32'd0);
        check("to.n", 32'(to_n), 32'd0);
        tick(1);
        check("to.req_ignored_go", 32'(to_go), 32'd0);
        check("to.req_ignored_busy", 32'(to_busy), 32'd0);
        check("to.start_hold", to_start, 32'd3);
        check("to.sel_count", 32'(to_sel_count), 32'd0);
        to_req = 1'b1; to_req_start = 32'd8;
        tick(1);
        to_req = 1'b0;
        check("to.err_clr", 32'(to_error), 32'd0);
        check("to.go2", 32'(to_go), 32'd1);
        check("to.start2", to_start, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
